ssd1306_frame_writer: RTL and testbench

SSD1306_FRAME_WRITER -- requirements
Module: ssd1306_frame_writer

---
 rtl/ssd1306_frame_writer_if.sv | 25 ++
 rtl/ssd1306_frame_writer.sv | 187 ++++++++++++++++++
 tb/tb_ssd1306_frame_writer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd1306_frame_writer_if.sv
// Byte-level handshake between the SSD1306 frame writer and its SPI transmit driver.
// The frame writer is the master; the SPI driver answers on command_ready.
interface ssd1306_frame_writer_if;
    logic       command_start;
    logic [7:0] command_out;
    logic       command_last_byte;
    logic       command_ready;
    logic       oled_dc;

    modport master (
        output command_start,
        output command_out,
        output command_last_byte,
        output oled_dc,
        input  command_ready
    );

    modport slave (
        input  command_start,
        input  command_out,
        input  command_last_byte,
        input  oled_dc,
        output command_ready
    );
endinterface

// File: rtl/ssd1306_frame_writer.sv
// Streams a full framebuffer to an SSD1306 over an SPI byte driver: 6-byte address header, then page-major data.
// Define FRAME_WRITER_CONTINUOUS_EN to keep refreshing frames back-to-back while init_done stays high.
module ssd1306_frame_writer #(
    parameter int unsigned COLUMNS = 128,
    parameter int unsigned PAGES   = 8
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          init_done,
    input  logic                          start,
    output logic                          busy,
    output logic                          frame_done,
    output logic [9:0]                    fb_addr,
    input  logic [7:0]                    fb_data,
    ssd1306_frame_writer_if.master        spi
);

    localparam int unsigned TOTAL     = COLUMNS * PAGES;
    localparam logic [9:0]  LAST_ADDR = 10'(TOTAL - 1);
    localparam logic [2:0]  HDR_LAST  = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        CMD_SEND,
        CMD_WAIT,
        FETCH,
        DATA_SEND,
        DATA_WAIT,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] hdr_idx_q, hdr_idx_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] cmd_q, cmd_d;
    logic       dc_q, dc_d;
    logic       last_q, last_d;
    logic       first_q, first_d;
    logic       start_pulse;

    function automatic logic [7:0] header_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h21;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'(COLUMNS - 1);
            3'd3:    b = 8'h22;
            3'd4:    b = 8'h00;
            default: b = 8'(PAGES - 1);
        endcase
        return b;
    endfunction

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            hdr_idx_q <= '0;
            addr_q    <= '0;
            cmd_q     <= '0;
            dc_q      <= 1'b0;
            last_q    <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            dc_q      <= dc_d;
            last_q    <= last_d;
            first_q   <= first_d;
        end
    end

    // first_q marks the first cycle of a WAIT state (ready not yet dropped) or of FETCH (read in flight).
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        dc_d        = dc_q;
        last_d      = last_q;
        first_d     = first_q;
        start_pulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && init_done) begin
                    state_d   = CMD_SEND;
                    hdr_idx_d = '0;
                    cmd_d     = header_byte(3'd0);
                    dc_d      = 1'b0;
                    last_d    = 1'b0;
                end
            end
            CMD_SEND: begin
                if (spi.command_ready) begin
                    start_pulse = 1'b1;
                    first_d     = 1'b1;
                    state_d     = CMD_WAIT;
                end
            end
            CMD_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (spi.command_ready) begin
                    if (hdr_idx_q == HDR_LAST) begin
                        state_d = FETCH;
                        addr_d  = '0;
                        dc_d    = 1'b1;
                        last_d  = 1'b0;
                        first_d = 1'b1;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                        cmd_d     = header_byte(hdr_idx_q + 3'd1);
                        last_d    = ((hdr_idx_q + 3'd1) == HDR_LAST);
                        state_d   = CMD_SEND;
                    end
                end
            end
            FETCH: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else begin
                    cmd_d   = fb_data;
                    last_d  = (addr_q == LAST_ADDR);
                    state_d = DATA_SEND;
                end
            end
            DATA_SEND: begin
                if (spi.command_ready) begin
                    start_pulse = 1'b1;
                    first_d     = 1'b1;
                    state_d     = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (spi.command_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 10'd1;
                        first_d = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                addr_d = '0;
                dc_d   = 1'b0;
                last_d = 1'b0;
`ifdef FRAME_WRITER_CONTINUOUS_EN
                if (init_done) begin
                    state_d   = CMD_SEND;
                    hdr_idx_d = '0;
                    cmd_d     = header_byte(3'd0);
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Losing init_done abandons the frame immediately; no byte may start in that cycle.
        if (state_q != IDLE && !init_done) begin
            state_d     = IDLE;
            start_pulse = 1'b0;
            addr_d      = '0;
            dc_d        = 1'b0;
            last_d      = 1'b0;
            first_d     = 1'b0;
        end
    end

    assign busy                  = (state_q != IDLE);
    assign frame_done            = (state_q == DONE);
    assign fb_addr               = addr_q;
    assign spi.command_start     = start_pulse;
    assign spi.command_out       = cmd_q;
    assign spi.command_last_byte = last_q;
    assign spi.oled_dc           = dc_q;

endmodule

// File: tb/tb_ssd1306_frame_writer.sv
// Directed bench: a 4x2 frame writer and a 1x1 instance, each behind an SPI driver model with 8-cycle byte time.
// Define FRAME_WRITER_CONTINUOUS_EN to exercise continuous refresh instead of the single-frame sequence.
module tb_ssd1306_frame_writer;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       reset_in, init_done, start;
    logic       busy, frame_done, busy1, frame_done1;
    logic [9:0] fb_addr, fb_addr1;
    logic [7:0] fb_data, fb_data1;

    ssd1306_frame_writer_if spi ();
    ssd1306_frame_writer_if spi1 ();

    ssd1306_frame_writer #(.COLUMNS(4), .PAGES(2)) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .init_done  (init_done),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .spi        (spi)
    );

    ssd1306_frame_writer #(.COLUMNS(1), .PAGES(1)) dut1 (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .init_done  (init_done),
        .start      (start),
        .busy       (busy1),
        .frame_done (frame_done1),
        .fb_addr    (fb_addr1),
        .fb_data    (fb_data1),
        .spi        (spi1)
    );

    // Synchronous-read framebuffers: fb[i] = 0x10+i for the 4x2 display, 0xA5 for the 1x1.
    always @(posedge clk_in) begin
        fb_data  <= 8'h10 + fb_addr[7:0];
        fb_data1 <= 8'hA5 ^ fb_addr1[7:0];
    end

    logic [9:0]  log0[$];
    logic [9:0]  log1[$];
    int unsigned fd0 = 0, fd1 = 0, viol0 = 0, viol1 = 0, unstable0 = 0;
    int unsigned cnt0 = 0, cnt1 = 0;
    logic [8:0]  held0 = '0;

    always @(posedge clk_in) begin
        if (spi.command_start) begin
            log0.push_back({spi.oled_dc, spi.command_last_byte, spi.command_out});
            held0 <= {spi.oled_dc, spi.command_out};
            if (!spi.command_ready) viol0 <= viol0 + 1;
        end else if (busy && !spi.command_ready && ({spi.oled_dc, spi.command_out} != held0)) begin
            unstable0 <= unstable0 + 1;
        end
        if (frame_done) fd0 <= fd0 + 1;
        if (reset_in) begin
            spi.command_ready <= 1'b1;
            cnt0 <= 0;
        end else if (spi.command_start) begin
            spi.command_ready <= 1'b0;
            cnt0 <= 8;
        end else if (cnt0 > 1) begin
            cnt0 <= cnt0 - 1;
        end else if (cnt0 == 1) begin
            cnt0 <= 0;
            spi.command_ready <= 1'b1;
        end
    end

    always @(posedge clk_in) begin
        if (spi1.command_start) begin
            log1.push_back({spi1.oled_dc, spi1.command_last_byte, spi1.command_out});
            if (!spi1.command_ready) viol1 <= viol1 + 1;
        end
        if (frame_done1) fd1 <= fd1 + 1;
        if (reset_in) begin
            spi1.command_ready <= 1'b1;
            cnt1 <= 0;
        end else if (spi1.command_start) begin
            spi1.command_ready <= 1'b0;
            cnt1 <= 8;
        end else if (cnt1 > 1) begin
            cnt1 <= cnt1 - 1;
        end else if (cnt1 == 1) begin
            cnt1 <= 0;
            spi1.command_ready <= 1'b1;
        end
    end

    int unsigned checks = 0, errors = 0;
    int unsigned b, b1, f, f1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] exp_hdr(input int i, input logic [7:0] cm1, input logic [7:0] pm1);
        logic [7:0] v;
        case (i)
            0:       v = 8'h21;
            1:       v = 8'h00;
            2:       v = cm1;
            3:       v = 8'h22;
            4:       v = 8'h00;
            default: v = pm1;
        endcase
        return {1'b0, (i == 5), v};
    endfunction

    function automatic logic [9:0] exp0_at(input int i);
        if (i < 6) return exp_hdr(i, 8'h03, 8'h01);
        return {1'b1, (i == 13), 8'h10 + 8'(i - 6)};
    endfunction

    function automatic logic [9:0] exp1_at(input int i);
        if (i < 6) return exp_hdr(i, 8'h00, 8'h00);
        return {1'b1, 1'b1, 8'hA5};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic wait_fd(input int unsigned target, input int budget);
        for (int i = 0; i < budget && fd0 < target; i++) @(negedge clk_in);
    endtask

    task automatic wait_log(input int unsigned target, input int budget);
        for (int i = 0; i < budget && 32'(log0.size()) < target; i++) @(negedge clk_in);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_frame_done"}, 32'(frame_done), 0);
        check({pfx, "_command_start"}, 32'(spi.command_start), 0);
        check({pfx, "_last_byte"}, 32'(spi.command_last_byte), 0);
        check({pfx, "_oled_dc"}, 32'(spi.oled_dc), 0);
        check({pfx, "_command_out"}, 32'(spi.command_out), 0);
        check({pfx, "_fb_addr"}, 32'(fb_addr), 0);
    endtask

    initial begin
        reset_in  = 1'b1;
        init_done = 1'b0;
        start     = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset");
        reset_in = 1'b0;
        @(negedge clk_in);

        // start ignored without init_done
        b = 32'(log0.size());
        pulse_start();
        check("noinit_busy", 32'(busy), 0);
        repeat (20) @(negedge clk_in);
        check("noinit_bytes", 32'(log0.size()) - b, 0);
        check("noinit_busy_later", 32'(busy), 0);
        init_done = 1'b1;
        @(negedge clk_in);

`ifdef FRAME_WRITER_CONTINUOUS_EN
        b = 32'(log0.size());
        f = fd0;
        pulse_start();
        check("cont_busy", 32'(busy), 1);
        wait_fd(f + 3, 3000);
        init_done = 1'b0;
        repeat (20) @(negedge clk_in);
        check("cont_frames", fd0 - f, 3);
        check("cont_bytes", 32'(log0.size()) - b, 42);
        for (int i = 0; i < 42; i++)
            check($sformatf("cont_byte%0d", i), 32'(log0[b + i]), 32'(exp0_at(i % 14)));
        check("cont_idle", 32'(busy), 0);
        init_done = 1'b1;
`else
        // full frame on both instances
        b  = 32'(log0.size());
        b1 = 32'(log1.size());
        f  = fd0;
        f1 = fd1;
        pulse_start();
        check("frame_busy", 32'(busy), 1);
        wait_fd(f + 1, 1000);
        repeat (5) @(negedge clk_in);
        check("frame_bytes", 32'(log0.size()) - b, 14);
        for (int i = 0; i < 14; i++)
            check($sformatf("frame_byte%0d", i), 32'(log0[b + i]), 32'(exp0_at(i)));
        check("frame_done_count", fd0 - f, 1);
        check("frame_busy_after", 32'(busy), 0);
        check("frame_fb_addr_after", 32'(fb_addr), 0);
        check("tiny_bytes", 32'(log1.size()) - b1, 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("tiny_byte%0d", i), 32'(log1[b1 + i]), 32'(exp1_at(i)));
        check("tiny_done_count", fd1 - f1, 1);

        // second start during data phase
        b = 32'(log0.size());
        f = fd0;
        pulse_start();
        wait_log(b + 8, 500);
        pulse_start();
        wait_fd(f + 1, 1000);
        repeat (40) @(negedge clk_in);
        check("restart_bytes", 32'(log0.size()) - b, 14);
        check("restart_done_count", fd0 - f, 1);
        check("restart_last", 32'(log0[b + 13]), 32'(exp0_at(13)));

        // init_done lost after the third data byte
        b = 32'(log0.size());
        f = fd0;
        pulse_start();
        wait_log(b + 9, 500);
        init_done = 1'b0;
        @(negedge clk_in);
        check("abort_busy", 32'(busy), 0);
        repeat (40) @(negedge clk_in);
        check("abort_bytes", 32'(log0.size()) - b, 9);
        check("abort_done_count", fd0 - f, 0);
        init_done = 1'b1;
        @(negedge clk_in);

        // reset mid-header
        b = 32'(log0.size());
        pulse_start();
        wait_log(b + 3, 200);
        reset_in = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("midreset");
        reset_in = 1'b0;
        repeat (30) @(negedge clk_in);
        check("midreset_bytes", 32'(log0.size()) - b, 3);
        b = 32'(log0.size());
        f = fd0;
        pulse_start();
        wait_fd(f + 1, 1000);
        repeat (5) @(negedge clk_in);
        check("replay_first", 32'(log0[b]), 32'(exp0_at(0)));
        check("replay_bytes", 32'(log0.size()) - b, 14);
`endif

        check("ready_violations", viol0, 0);
        check("tiny_ready_violations", viol1, 0);
        check("byte_stability", unstable0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
